// File: rtl/led_matrix_pkg.sv
// Shared types, constants and the RGB332 level decode for the LED matrix scan path.
package led_matrix_pkg;

    localparam int PANEL_DIM   = 8;
    localparam int IDX_BITS    = 3;
    localparam int ADDR_WIDTH  = 6;
    localparam int COLOR_DEPTH = 8;
    localparam int PWM_BITS    = 3;
    localparam int PWM_STEPS   = 8;

    typedef enum logic [1:0] {IDLE, FETCH, BLANK, SHOW} scan_state_t;

    typedef struct packed {
        logic [PWM_BITS-1:0] r;
        logic [PWM_BITS-1:0] g;
        logic [PWM_BITS-1:0] b;
    } rgb_levels_t;

    // Blue has only two bits; replicating the MSB spreads them over 0..7.
    function automatic rgb_levels_t rgb332_levels(input logic [COLOR_DEPTH-1:0] pix);
        rgb_levels_t lv;
        lv.r = pix[7:5];
        lv.g = pix[4:2];
        lv.b = {pix[1:0], pix[1]};
        return lv;
    endfunction

endpackage

// File: rtl/pwm_column_slice.sv
// One panel column: turns a latched RGB332 pixel into r/g/b drive for the current PWM step.
// Purely combinational; the top registers the result.
module pwm_column_slice
    import led_matrix_pkg::*;
(
    input  logic [COLOR_DEPTH-1:0] i_pixel,
    input  logic [PWM_BITS-1:0]    i_step,
    input  logic                   i_show,
    input  logic                   i_active_low,
    output logic                   o_r,
    output logic                   o_g,
    output logic                   o_b
);

    rgb_levels_t w_lv;

    assign w_lv = rgb332_levels(i_pixel);
    assign o_r  = (i_show && (i_step < w_lv.r)) ^ i_active_low;
    assign o_g  = (i_show && (i_step < w_lv.g)) ^ i_active_low;
    assign o_b  = (i_show && (i_step < w_lv.b)) ^ i_active_low;

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-multiplexed 8x8 RGB panel driver: fetch a row into a shadow register, blank, then PWM-show it.
// All panel outputs are registered and trail the scan state by one cycle.
module matrix_scan_driver
    import led_matrix_pkg::*;
#(
    parameter int MATRIX_SIZE    = PANEL_DIM,
    parameter int STEP_CYCLES    = 64,
    parameter int DEAD_CYCLES    = 16,
    parameter int ROW_ACTIVE_LOW = 0,
    parameter int COL_ACTIVE_LOW = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    output logic [ADDR_WIDTH-1:0]  read_addr,
    input  logic [COLOR_DEPTH-1:0] pixel_data,
    output logic [MATRIX_SIZE-1:0] row_sel,
    output logic [MATRIX_SIZE-1:0] col_r,
    output logic [MATRIX_SIZE-1:0] col_g,
    output logic [MATRIX_SIZE-1:0] col_b,
    output logic                   frame_done,
    output logic                   scan_active
);

    localparam int MAX_A   = (STEP_CYCLES > DEAD_CYCLES) ? STEP_CYCLES : DEAD_CYCLES;
    localparam int MAX_CNT = (MAX_A > MATRIX_SIZE) ? MAX_A : MATRIX_SIZE;
    localparam int CNT_W   = $clog2(MAX_CNT);

    localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]       FETCH_LAST = CNT_W'(MATRIX_SIZE - 1);
    localparam logic [CNT_W-1:0]       DEAD_LAST  = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]       STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0]    PWM_LAST   = PWM_BITS'(PWM_STEPS - 1);
    localparam logic [IDX_BITS-1:0]    ROW_LAST   = IDX_BITS'(MATRIX_SIZE - 1);
    localparam logic [IDX_BITS-1:0]    IDX_ONE    = IDX_BITS'(1);
    localparam logic [MATRIX_SIZE-1:0] ROW_ONE    = MATRIX_SIZE'(1);
    localparam logic                   ROW_POL    = (ROW_ACTIVE_LOW != 0);
    localparam logic                   COL_POL    = (COL_ACTIVE_LOW != 0);
    localparam scan_state_t            POST_FETCH = (DEAD_CYCLES == 0) ? SHOW : BLANK;

    scan_state_t            r_state;
    logic [IDX_BITS-1:0]    r_row;
    logic [CNT_W-1:0]       r_cnt;
    logic [PWM_BITS-1:0]    r_step;
    logic [COLOR_DEPTH-1:0] r_shadow [MATRIX_SIZE];
    logic [ADDR_WIDTH-1:0]  r_read_addr;
    logic                   r_frame_done;
    logic                   r_scan_active;
    logic [MATRIX_SIZE-1:0] r_row_sel;
    logic [MATRIX_SIZE-1:0] r_col_r;
    logic [MATRIX_SIZE-1:0] r_col_g;
    logic [MATRIX_SIZE-1:0] r_col_b;

    logic [IDX_BITS-1:0]    w_col;
    logic                   w_show;
    logic [MATRIX_SIZE-1:0] w_col_r;
    logic [MATRIX_SIZE-1:0] w_col_g;
    logic [MATRIX_SIZE-1:0] w_col_b;

    assign w_col  = r_cnt[IDX_BITS-1:0];
    assign w_show = enable && (r_state == SHOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_row         <= '0;
            r_cnt         <= '0;
            r_step        <= '0;
            r_read_addr   <= '0;
            r_frame_done  <= 1'b0;
            r_scan_active <= 1'b0;
            for (int i = 0; i < MATRIX_SIZE; i++) r_shadow[i] <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (!enable) begin
                r_state       <= IDLE;
                r_row         <= '0;
                r_cnt         <= '0;
                r_step        <= '0;
                r_scan_active <= 1'b0;
            end else begin
                r_scan_active <= 1'b1;
                case (r_state)
                    IDLE: begin
                        r_state     <= FETCH;
                        r_cnt       <= '0;
                        r_read_addr <= '0;
                    end
                    FETCH: begin
                        r_shadow[w_col] <= pixel_data;
                        if (r_cnt == FETCH_LAST) begin
                            r_cnt   <= '0;
                            r_step  <= '0;
                            r_state <= POST_FETCH;
                        end else begin
                            r_cnt       <= r_cnt + CNT_ONE;
                            r_read_addr <= {r_row, w_col + IDX_ONE};
                        end
                    end
                    BLANK: begin
                        if (r_cnt == DEAD_LAST) begin
                            r_cnt   <= '0;
                            r_state <= SHOW;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    SHOW: begin
                        if (r_cnt != STEP_LAST) begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end else begin
                            r_cnt <= '0;
                            if (r_step != PWM_LAST) begin
                                r_step <= r_step + PWM_BITS'(1);
                            end else begin
                                r_step  <= '0;
                                r_state <= FETCH;
                                // Address of the next row's first pixel is ready for FETCH cycle 0.
                                if (r_row == ROW_LAST) begin
                                    r_row        <= '0;
                                    r_frame_done <= 1'b1;
                                    r_read_addr  <= '0;
                                end else begin
                                    r_row       <= r_row + IDX_ONE;
                                    r_read_addr <= {r_row + IDX_ONE, {IDX_BITS{1'b0}}};
                                end
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < MATRIX_SIZE; gi++) begin : g_col
        pwm_column_slice u_slice (
            .i_pixel      (r_shadow[gi]),
            .i_step       (r_step),
            .i_show       (w_show),
            .i_active_low (COL_POL),
            .o_r          (w_col_r[gi]),
            .o_g          (w_col_g[gi]),
            .o_b          (w_col_b[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_sel <= {MATRIX_SIZE{ROW_POL}};
            r_col_r   <= {MATRIX_SIZE{COL_POL}};
            r_col_g   <= {MATRIX_SIZE{COL_POL}};
            r_col_b   <= {MATRIX_SIZE{COL_POL}};
        end else begin
            r_row_sel <= w_show ? ((ROW_ONE << r_row) ^ {MATRIX_SIZE{ROW_POL}})
                                : {MATRIX_SIZE{ROW_POL}};
            r_col_r   <= w_col_r;
            r_col_g   <= w_col_g;
            r_col_b   <= w_col_b;
        end
    end

    assign read_addr   = r_read_addr;
    assign row_sel     = r_row_sel;
    assign col_r       = r_col_r;
    assign col_g       = r_col_g;
    assign col_b       = r_col_b;
    assign frame_done  = r_frame_done;
    assign scan_active = r_scan_active;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Bench for matrix_scan_driver: two instances (default and fast/inverted) checked against a
// timeline model of the scan, compared as run-length segments of the full output vector.
module tb_matrix_scan_driver;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    always #5 clk = ~clk;

    logic [7:0] mem [64];

    logic [5:0] ra0, ra1;
    logic [7:0] pd0, pd1;
    logic [7:0] rs0, cr0, cg0, cb0, rs1, cr1, cg1, cb1;
    logic       fd0, sa0, fd1, sa1;

    assign pd0 = mem[ra0];
    assign pd1 = mem[ra1];

    matrix_scan_driver u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .read_addr(ra0), .pixel_data(pd0),
        .row_sel(rs0), .col_r(cr0), .col_g(cg0), .col_b(cb0),
        .frame_done(fd0), .scan_active(sa0)
    );

    matrix_scan_driver #(
        .STEP_CYCLES(3), .DEAD_CYCLES(0), .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .read_addr(ra1), .pixel_data(pd1),
        .row_sel(rs1), .col_r(cr1), .col_g(cg1), .col_b(cb1),
        .frame_done(fd1), .scan_active(sa1)
    );

    logic [39:0] mv0, mv1;
    assign mv0 = {sa0, fd0, rs0, cr0, cg0, cb0, ra0};
    assign mv1 = {sa1, fd1, rs1, cr1, cg1, cb1, ra1};

    typedef struct packed {
        logic [39:0] val;
        int          len;   // 0 = length not checked
    } seg_t;

    seg_t q0[$];
    seg_t q1[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    function automatic int blue_level(input int b2);
        case (b2)
            0:       return 0;
            1:       return 2;
            2:       return 5;
            default: return 7;
        endcase
    endfunction

    function automatic logic [39:0] idle_val(input int id, input logic [5:0] ra);
        logic pol;
        pol = (id != 0);
        return {1'b0, 1'b0, {8{pol}}, {24{pol}}, ra};
    endfunction

    // Output vector seen in cycle c after the first edge that sampled enable high.
    function automatic logic [39:0] exp_at(input int id, input int c);
        int S, D, R, p, r, q, pr, rr, s, pv;
        logic pol, fd;
        logic [7:0] rs, cr, cg, cb;
        logic [5:0] ra;
        S   = (id == 0) ? 64 : 3;
        D   = (id == 0) ? 16 : 0;
        pol = (id != 0);
        R   = 8 + D + 8 * S;
        p   = c % R;
        r   = (c / R) % 8;
        ra  = 6'(r * 8 + ((p < 8) ? p : 7));
        rs = '0; cr = '0; cg = '0; cb = '0; fd = 1'b0;
        if (c >= 1) begin
            q  = c - 1;
            pr = q % R;
            rr = (q / R) % 8;
            fd = ((q % (8 * R)) == (8 * R - 1));
            if (pr >= 8 + D) begin
                s = (pr - 8 - D) / S;
                rs[rr] = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    pv    = int'(mem[6'(rr * 8 + k)]);
                    cr[k] = (s < pv / 32);
                    cg[k] = (s < (pv / 4) % 8);
                    cb[k] = (s < blue_level(pv % 4));
                end
            end
        end
        return {1'b1, fd, rs ^ {8{pol}}, cr ^ {8{pol}}, cg ^ {8{pol}}, cb ^ {8{pol}}, ra};
    endfunction

    task automatic push(input int id, input logic [39:0] v, input int n);
        seg_t e;
        e.val = v;
        e.len = n;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Queue the expected segments, then hold enable high for len sampling edges.
    task automatic run(input int len);
        logic [39:0] cur, v;
        int n;
        for (int id = 0; id < 2; id++) begin
            cur = exp_at(id, 0);
            n   = 1;
            for (int c = 1; c < len; c++) begin
                v = exp_at(id, c);
                if (v == cur) n++;
                else begin
                    push(id, cur, n);
                    cur = v;
                    n   = 1;
                end
            end
            push(id, cur, n);
            push(id, idle_val(id, cur[5:0]), 0);
        end
        @(negedge clk);
        enable = 1'b1;
        repeat (len) @(negedge clk);
        enable = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic close_seg(input int id, input logic [39:0] v, input int n, input bit chk_len);
        seg_t e;
        int   sz;
        sz = (id == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL dut%0d_seg_extra: actual %h for %0d cycles required none", id, v, n);
            return;
        end
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        check($sformatf("dut%0d_seg_val", id), 64'(v), 64'(e.val));
        if (chk_len && e.len != 0)
            check($sformatf("dut%0d_seg_len(val %h)", id, e.val), 64'(n), 64'(e.len));
    endtask

    task automatic monitor(input int id);
        logic [39:0] cur, v;
        int n;
        @(posedge rst_n);
        @(negedge clk);
        cur = (id != 0) ? mv1 : mv0;
        n   = 1;
        while (mon_en) begin
            @(negedge clk);
            v = (id != 0) ? mv1 : mv0;
            if (v == cur) n++;
            else begin
                close_seg(id, cur, n, 1'b1);
                cur = v;
                n   = 1;
            end
        end
        close_seg(id, cur, n, 1'b0);
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 64; i++) mem[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        fill(8'h00);
        push(0, idle_val(0, 6'd0), 0);
        push(1, idle_val(1, 6'd0), 0);
        repeat (3) @(negedge clk);
        check("reset_dut0", 64'(mv0), 64'(idle_val(0, 6'd0)));
        check("reset_dut1", 64'(mv1), 64'(idle_val(1, 6'd0)));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fill(8'hFF);
        run(2 * 536 + 10);

        fill(8'h00);
        mem[9] = 8'hE0;
        run(2 * 536 + 30);

        fill(8'h00);
        mem[0] = 8'h03;
        mem[1] = 8'h01;
        run(540);

        fill_rand();
        run(2 * 4288 + 50);

        fill_rand();
        run(3 * 536 + 24 + 200);     // drops enable during row 3 show

        fill_rand();
        run(600);

        for (int t = 0; t < 2; t++) begin
            fill_rand();
            run($urandom_range(700, 2500));
        end

        mon_en = 1'b0;
        repeat (3) @(negedge clk);
        check("dut0_queue_drained", 64'(q0.size()), 64'd0);
        check("dut1_queue_drained", 64'(q1.size()), 64'd0);

        fill(8'hFF);
        enable = 1'b1;
        repeat (100) @(negedge clk);
        check("pre_reset_row_sel", 64'(rs0), 64'h01);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_dut0", 64'(mv0), 64'(idle_val(0, 6'd0)));
        check("async_reset_dut1", 64'(mv1), 64'(idle_val(1, 6'd0)));
        enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
